rv_fetch_instr_queue: RTL and testbench

// - Instruction prefetch queue between the instruction-bus fetch logic and decode.
// - Stores fetched halfwords (RVC) or words (RV32 only) in a circular FIFO.
// - Presents the head instruction together with its PC and next-sequential PC.
// - Pops one variable-length instruction (16/32-bit) per accepted cycle.
// - Tracks the head PC with an internal ripple adder, so the queue is self-contained.

---
 rtl/rv_fetch_instr_queue.sv | 230 +++++++++++++++++++++++
 tb/tb_rv_fetch_instr_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_instr_queue.sv
// rv_fetch_instr_queue: instruction prefetch queue sitting between the
// instruction-bus fetch logic and decode. Fetched halfwords (WIDTH=16, RVC
// enabled) or words (WIDTH=32, RV32 only) are held in a circular buffer; the
// head instruction is presented with its PC and next-sequential PC, and one
// 16- or 32-bit instruction is consumed per accepted pop.
//
// Optional feature macro: RV_FETCH_QUEUE_CHECK_EN
//   defined   -> simulation-only protocol checks at each clock edge
//   undefined -> no checking logic, identical functional behaviour

`ifdef RV_FETCH_QUEUE_CHECK_EN
// Protocol checker: flags caller misuse and internal occupancy overflow.
module rv_fetch_instr_queue_chk #(
  parameter int DEPTH_BITS = 2
) (
  input logic                  i_clk,
  input logic                  i_reset,
  input logic                  i_push_single,
  input logic                  i_push_double,
  input logic                  i_full,
  input logic [DEPTH_BITS:0]   i_count
);

  localparam int CW = DEPTH_BITS + 1;
  localparam int DEPTH = 1 << DEPTH_BITS;

  // Check push/occupancy rules on every edge outside reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!((i_push_single | i_push_double) && i_full))
        else $error("rv_fetch_instr_queue: push while full");
      assert (!(i_push_single && i_push_double))
        else $error("rv_fetch_instr_queue: single and double push together");
      assert (i_count <= CW'(DEPTH))
        else $error("rv_fetch_instr_queue: count exceeds depth");
    end
  end

endmodule
`endif

module rv_fetch_instr_queue #(
  parameter int IADDR_SPACE_BITS = 16,
  parameter int WIDTH            = 16,
  parameter int DEPTH_BITS       = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [IADDR_SPACE_BITS-1:1]   i_pc,
  input  logic [WIDTH-1:0]              i_data_lo,
  input  logic [WIDTH-1:0]              i_data_hi,
  input  logic                          i_push_single,
  input  logic                          i_push_double,
  input  logic                          i_pop,
  output logic [WIDTH-1:0]              o_data_lo,
  output logic [WIDTH-1:0]              o_data_hi,
  output logic [IADDR_SPACE_BITS-1:1]   o_pc,
  output logic [IADDR_SPACE_BITS-1:1]   o_pc_next,
  output logic                          o_empty,
  output logic                          o_full
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CW    = DEPTH_BITS + 1;
  localparam int PCW   = IADDR_SPACE_BITS - 1;
  // Halfword entries mean compressed instructions are possible.
  localparam bit RVC   = (WIDTH == 16);

  // Ripple-carry adder for the halfword PC; carry-in 0, carry-out dropped,
  // so the result wraps modulo 2**PCW.
  function automatic logic [PCW-1:0] ripple_add(input logic [PCW-1:0] a,
                                                input logic [PCW-1:0] b);
    logic [PCW-1:0] sum;
    logic           carry;
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < PCW; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    return sum;
  endfunction

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_p1_s, wr_ptr_p1_s;
  logic [CW-1:0]         count_q, count_d;
  logic [PCW-1:0]        pc_q, pc_d;

  logic [CW-1:0]         free_s;
  logic [CW-1:0]         push_req_s;
  logic [CW-1:0]         push_acc_s;
  logic [CW-1:0]         pop_len_s;
  logic [PCW-1:0]        pc_inc_s;
  logic [PCW-1:0]        pc_next_s;
  logic                  head_long_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  pop_acc_s;
  logic [WIDTH-1:0]      ent0_s, ent1_s;

  assign rd_ptr_p1_s = rd_ptr_q + DEPTH_BITS'(1);
  assign wr_ptr_p1_s = wr_ptr_q + DEPTH_BITS'(1);

  assign o_data_lo = mem_q[rd_ptr_q];
  assign o_data_hi = mem_q[rd_ptr_p1_s];
  assign o_pc      = pc_q;
  assign o_pc_next = pc_next_s;
  assign o_empty   = empty_s;
  assign o_full    = full_s;

  // Head decode: instruction length, occupancy flags and next PC.
  always_comb begin
    head_long_s = RVC && (mem_q[rd_ptr_q][1:0] == 2'b11);
    free_s      = CW'(DEPTH) - count_q;
    // A lone upper-less half of a 32-bit instruction is not yet usable.
    empty_s     = (count_q == CW'(0)) ||
                  (RVC && (count_q == CW'(1)) && head_long_s);
    if (RVC) begin
      full_s = (free_s < CW'(2));
    end else begin
      full_s = (free_s < CW'(1));
    end
    if (head_long_s || !RVC) begin
      pop_len_s = RVC ? CW'(2) : CW'(1);
      pc_inc_s  = PCW'(2);
    end else begin
      pop_len_s = CW'(1);
      pc_inc_s  = PCW'(1);
    end
    pc_next_s = ripple_add(pc_q, pc_inc_s);
    pop_acc_s = i_pop & ~empty_s;
  end

  // Push decode: which entries to write and how many fit.
  always_comb begin
    ent0_s     = '0;
    ent1_s     = '0;
    push_req_s = CW'(0);
    if (RVC) begin
      if (i_push_double) begin
        ent0_s     = i_data_lo;
        ent1_s     = i_data_hi;
        push_req_s = CW'(2);
      end else if (i_push_single) begin
        ent0_s     = i_data_hi;
        push_req_s = CW'(1);
      end else begin
        push_req_s = CW'(0);
      end
    end else begin
      if (i_push_single | i_push_double) begin
        ent0_s     = i_data_lo;
        push_req_s = CW'(1);
      end else begin
        push_req_s = CW'(0);
      end
    end
    // Entries beyond the free space are dropped so count never exceeds DEPTH.
    if (push_req_s > free_s) begin
      push_acc_s = free_s;
    end else begin
      push_acc_s = push_req_s;
    end
  end

  // Next-state: storage writes, pointer advance, count and PC update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + push_acc_s[DEPTH_BITS-1:0];
    rd_ptr_d = rd_ptr_q;
    pc_d     = pc_q;
    count_d  = count_q;
    case (push_acc_s)
      CW'(1): begin
        mem_d[wr_ptr_q] = ent0_s;
      end
      CW'(2): begin
        mem_d[wr_ptr_q]    = ent0_s;
        mem_d[wr_ptr_p1_s] = ent1_s;
      end
      default: begin
      end
    endcase
    // Pop acceptance is based on pre-push contents (no bypass).
    if (pop_acc_s) begin
      rd_ptr_d = rd_ptr_q + pop_len_s[DEPTH_BITS-1:0];
      pc_d     = pc_next_s;
      count_d  = count_q + push_acc_s - pop_len_s;
    end else begin
      count_d  = count_q + push_acc_s;
    end
  end

  // State registers; reset doubles as a flush that reloads the PC.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= i_pc;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
    end
  end

`ifdef RV_FETCH_QUEUE_CHECK_EN
  rv_fetch_instr_queue_chk #(
    .DEPTH_BITS(DEPTH_BITS)
  ) u_chk (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_push_single (i_push_single),
    .i_push_double (i_push_double),
    .i_full        (full_s),
    .i_count       (count_q)
  );
`else
`endif

endmodule

// File: tb/tb_rv_fetch_instr_queue.sv
// Bench for rv_fetch_instr_queue (WIDTH=16, DEPTH=4): a halfword-queue model
// is checked against the DUT every cycle, plus literal expectations.
module tb_rv_fetch_instr_queue;

  localparam int AW    = 16;
  localparam int W     = 16;
  localparam int DB    = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [14:0] i_pc;
  logic [15:0] i_data_lo, i_data_hi;
  logic        i_push_single, i_push_double, i_pop;
  logic [15:0] o_data_lo, o_data_hi;
  logic [14:0] o_pc, o_pc_next;
  logic        o_empty, o_full;

  always #5 clk = ~clk;

  rv_fetch_instr_queue #(
    .IADDR_SPACE_BITS(AW), .WIDTH(W), .DEPTH_BITS(DB)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_pc(i_pc),
    .i_data_lo(i_data_lo), .i_data_hi(i_data_hi),
    .i_push_single(i_push_single), .i_push_double(i_push_double), .i_pop(i_pop),
    .o_data_lo(o_data_lo), .o_data_hi(o_data_hi),
    .o_pc(o_pc), .o_pc_next(o_pc_next), .o_empty(o_empty), .o_full(o_full)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: queue of pending halfwords and the PC of the head.
  logic [15:0] mq[$];
  logic [14:0] m_pc;

  function automatic bit m_long();
    return (mq.size() > 0) && (mq[0][1:0] == 2'b11);
  endfunction

  function automatic bit m_empty();
    return (mq.size() == 0) || ((mq.size() == 1) && (mq[0][1:0] == 2'b11));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    int len;
    if (i_reset) begin
      mq.delete();
      m_pc = i_pc;
    end else begin
      if (i_pop && !m_empty()) begin
        len = m_long() ? 2 : 1;
        repeat (len) void'(mq.pop_front());
        m_pc = m_pc + 15'(len);
      end
      if (i_push_double) begin
        mq.push_back(i_data_lo);
        mq.push_back(i_data_hi);
      end else if (i_push_single) begin
        mq.push_back(i_data_hi);
      end
    end
  endtask

  task automatic compare_outputs();
    logic [14:0] exp_next;
    chk("empty", o_empty, m_empty());
    chk("full", o_full, (DEPTH - mq.size()) < 2);
    chk("pc", o_pc, m_pc);
    if (mq.size() > 0) chk("data_lo", o_data_lo, mq[0]);
    if (!m_empty()) begin
      exp_next = m_pc + (m_long() ? 15'd2 : 15'd1);
      chk("pc_next", o_pc_next, exp_next);
      if (m_long()) chk("data_hi", o_data_hi, mq[1]);
    end
  endtask

  // One clock: model follows the edge, then all outputs are compared.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic drive(input logic rst, input logic [14:0] pc,
                       input logic [15:0] lo, input logic [15:0] hi,
                       input logic s, input logic d, input logic p);
    i_reset = rst; i_pc = pc; i_data_lo = lo; i_data_hi = hi;
    i_push_single = s; i_push_double = d; i_pop = p;
  endtask

  initial begin
    drive(1'b1, 15'h0020, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tick(); tick();
    drive(1'b0, 15'h0020, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_empty", o_empty, 1'b1);
    chk("rst_full", o_full, 1'b0);
    chk("rst_pc", o_pc, 15'h0020);
    chk("rst_data_lo", o_data_lo, 16'h0000);

    // RVC pair.
    drive(1'b0, 15'h0, 16'h4501, 16'h0001, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("rvc_empty", o_empty, 1'b0);
    chk("rvc_pc_next", o_pc_next, 15'h0021);
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
    chk("rvc_pop_pc", o_pc, 15'h0021);
    chk("rvc_pop_data", o_data_lo, 16'h0001);
    tick();
    chk("rvc_drain_empty", o_empty, 1'b1);

    // 32-bit addi, pointers wrap.
    drive(1'b0, 15'h0, 16'h0513, 16'h0000, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("w32_pc_next", o_pc_next, 15'h0024);
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
    chk("w32_pop_empty", o_empty, 1'b1);
    chk("w32_pop_pc", o_pc, 15'h0024);

    // Lone upper half, then completed by a double push.
    drive(1'b0, 15'h0, 16'hDEAD, 16'h0513, 1'b1, 1'b0, 1'b0); tick();
    chk("half_empty", o_empty, 1'b1);
    drive(1'b0, 15'h0, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("half_done_empty", o_empty, 1'b0);
    chk("half_done_next", o_pc_next, 15'h0026);
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1); tick(); tick();
    chk("half_drain_pc", o_pc, 15'h0027);

    // Fill to full with two double pushes, drain RVC entries.
    drive(1'b0, 15'h0, 16'h4501, 16'h8082, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 15'h0, 16'h0001, 16'h4505, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("fill_full", o_full, 1'b1);
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1); tick(); tick();
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("drain_not_full", o_full, 1'b0);
    chk("drain_pc", o_pc, 15'h0029);

    // Same-cycle push and pop.
    drive(1'b0, 15'h0, 16'h0593, 16'h0010, 1'b0, 1'b1, 1'b1); tick();
    chk("pp_pc", o_pc, 15'h002A);
    chk("pp_full", o_full, 1'b1);
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("pp_long_next", o_pc_next, 15'h002D);
    chk("pp_long_hi", o_data_hi, 16'h0010);

    // Flush mid-stream; push/pop during flush are discarded.
    drive(1'b1, 15'h0100, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1); tick();
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_empty", o_empty, 1'b1);
    chk("flush_pc", o_pc, 15'h0100);
    chk("flush_data", o_data_lo, 16'h0000);
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
    chk("empty_pop_pc", o_pc, 15'h0100);

    // PC wrap at the top of the address space.
    drive(1'b1, 15'h7FFF, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 15'h0, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("wrap_next", o_pc_next, 15'h0000);
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 15'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("wrap_pc", o_pc, 15'h0000);
    chk("wrap_pc_next", o_pc_next, 15'h0001);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
